// File: rtl/alu_seq_core_if.sv
// Operand/result handshake bundle for alu_seq_core.
// The master side issues operations; the slave side returns results.
interface alu_seq_core_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             use_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_hi;
  logic [3:0]       flags;

  modport master (
    output in_valid, op, a, b, use_acc, out_ready,
    input  in_ready, out_valid, y, y_hi, flags
  );

  modport slave (
    input  in_valid, op, a, b, use_acc, out_ready,
    output in_ready, out_valid, y, y_hi, flags
  );
endinterface

// File: rtl/alu_seq_core.sv
// Registered ALU with valid/ready handshakes, an accumulator, status flags and a
// WIDTH-cycle shift-add multiplier. One operation is in flight at a time.
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  input logic           ena,
  alu_seq_core_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111
  } op_e;

  state_e             state_q;
  logic [SW-1:0]      cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   y_q, y_hi_q, acc_q;
  logic [3:0]         flags_q;
  logic               out_valid_q;

  logic               in_ready, accept;
  logic [WIDTH-1:0]   opa;
  logic [SW-1:0]      sh;
  logic [WIDTH:0]     sum, diff, shl, shr, mul_sum;
  logic [WIDTH-1:0]   alu_y_d;
  logic               alu_c, alu_v;
  logic [3:0]         alu_flags_d;
  logic [2*WIDTH-1:0] prod_d;

  // DONE only frees the slot when the consumer takes the result this cycle.
  assign in_ready = ena & ((state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;

  assign opa  = bus.use_acc ? acc_q : bus.a;
  assign sh   = bus.b[SW-1:0];
  assign sum  = {1'b0, opa} + {1'b0, bus.b};
  assign diff = {1'b0, opa} - {1'b0, bus.b};
  // One spare bit on the outgoing side catches the last bit shifted out.
  assign shl  = {1'b0, opa} << sh;
  assign shr  = {opa, 1'b0} >> sh;

  always_comb begin
    alu_y_d = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_e'(bus.op))
      OP_ADD: begin
        alu_y_d = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (opa[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y_d = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (opa[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_AND: alu_y_d = opa & bus.b;
      OP_OR:  alu_y_d = opa | bus.b;
      OP_XOR: alu_y_d = opa ^ bus.b;
      OP_SHL: begin
        alu_y_d = shl[WIDTH-1:0];
        alu_c   = shl[WIDTH];
      end
      OP_SHR: begin
        alu_y_d = shr[WIDTH:1];
        alu_c   = shr[0];
      end
      default: ;
    endcase
  end

  assign alu_flags_d = {alu_v, alu_y_d[WIDTH-1], alu_y_d == '0, alu_c};

  // prod_q = {partial high, remaining multiplier bits}; add then shift right.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_d  = {mul_sum, prod_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      y_q         <= '0;
      y_hi_q      <= '0;
      acc_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (ena) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (op_e'(bus.op) == OP_MUL) begin
              state_q     <= S_MUL;
              cnt_q       <= '0;
              mcand_q     <= opa;
              prod_q      <= {{WIDTH{1'b0}}, bus.b};
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= S_DONE;
              y_q         <= alu_y_d;
              y_hi_q      <= '0;
              flags_q     <= alu_flags_d;
              acc_q       <= alu_y_d;
              out_valid_q <= 1'b1;
            end
          end else if (state_q == S_DONE && bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        S_MUL: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q     <= S_DONE;
            y_q         <= prod_d[WIDTH-1:0];
            y_hi_q      <= prod_d[2*WIDTH-1:WIDTH];
            flags_q     <= {1'b0, prod_d[WIDTH-1], prod_d[WIDTH-1:0] == '0,
                            prod_d[2*WIDTH-1:WIDTH] != '0};
            acc_q       <= prod_d[WIDTH-1:0];
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.y_hi      = y_hi_q;
  assign bus.flags     = flags_q;
endmodule
